// File: rtl/glitch_filter.sv
// Optional 2-flop synchronizer followed by a stability filter: the output only
// follows the input once it has held a new level for LEN consecutive cycles.
module glitch_filter #(
  parameter int   LEN               = 2,
  parameter logic RST_VAL           = 1'b1,
  parameter bit   WITH_SYNCHRONIZER = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  logic          s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;

  if (WITH_SYNCHRONIZER) begin : g_sync
    logic [1:0] sync_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= {2{RST_VAL}};
      else     sync_q <= {sync_q[0], d_i};
    end
    assign s = sync_q[1];
  end else begin : g_nosync
    assign s = d_i;
  end

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (s == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(LEN - 1)) begin
      out_d = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      out_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign q_o = out_q;

endmodule

// File: rtl/uart_autobaud.sv
// Measures a 0x55 sync character and produces the UART divider (bit period - 2).
// States: IDLE wait start | WAIT_HIGH 16 idle-high cycles | ARMED wait 1st fall | MEASURE count to 5th fall | CALC divider
module uart_autobaud #(
  parameter int DIV_WIDTH     = 8,
  parameter int GLITCH_FILTER = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 start,
  output logic [DIV_WIDTH-1:0] div,
  output logic                 div_valid,
  output logic                 busy,
  output logic                 err
);

  localparam int CNT_W = DIV_WIDTH + 4;
  localparam int P_W   = CNT_W - 2;
  localparam logic [P_W-1:0] P_MIN = P_W'(3);
  localparam logic [P_W-1:0] P_MAX = P_W'((1 << DIV_WIDTH) + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_HIGH,
    S_ARMED,
    S_MEASURE,
    S_CALC
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]     cyc_q, cyc_d;
  logic [2:0]           edge_q, edge_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 div_valid_q, div_valid_d;
  logic                 err_q, err_d;
  logic                 rx_val;
  logic                 rx_prev_q;
  logic                 fall;
  logic [CNT_W:0]       cyc_sum;
  logic [P_W-1:0]       p;

  if (GLITCH_FILTER > 0) begin : g_filter
    glitch_filter #(
      .LEN              (GLITCH_FILTER),
      .RST_VAL          (1'b1),
      .WITH_SYNCHRONIZER(1'b1)
    ) u_glitch_filter (
      .clk(clk),
      .rst(rst),
      .d_i(rx),
      .q_o(rx_val)
    );
  end else begin : g_sync
    logic [1:0] sync_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], rx};
    end
    assign rx_val = sync_q[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_prev_q <= 1'b1;
    else     rx_prev_q <= rx_val;
  end

  assign fall    = rx_prev_q & ~rx_val;
  assign cyc_sum = {1'b0, cyc_q} + (CNT_W + 1)'(1);
  // Rounded bit period: N spans 8 bit times.
  assign p       = P_W'(({1'b0, cyc_q} + (CNT_W + 1)'(4)) >> 3);

  always_comb begin
    state_d     = state_q;
    hi_cnt_d    = hi_cnt_q;
    cyc_d       = cyc_q;
    edge_d      = edge_q;
    div_d       = div_q;
    div_valid_d = div_valid_q;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          div_valid_d = 1'b0;
          hi_cnt_d    = 4'd15;
          state_d     = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (!rx_val) begin
          hi_cnt_d = 4'd15;
        end else if (hi_cnt_q == 4'd0) begin
          state_d = S_ARMED;
        end else begin
          hi_cnt_d = hi_cnt_q - 4'd1;
        end
      end
      S_ARMED: begin
        if (fall) begin
          cyc_d   = '0;
          edge_d  = 3'd1;
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        // Overflow wins over a coincident fall strobe.
        if (cyc_sum[CNT_W]) begin
          err_d       = 1'b1;
          div_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          cyc_d = cyc_sum[CNT_W-1:0];
          if (fall) begin
            edge_d = edge_q + 3'd1;
            if (edge_q == 3'd4) state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (p < P_MIN || p > P_MAX) begin
          err_d = 1'b1;
        end else begin
          div_d       = DIV_WIDTH'(p - P_W'(2));
          div_valid_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hi_cnt_q    <= '0;
      cyc_q       <= '0;
      edge_q      <= '0;
      div_q       <= '0;
      div_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_cnt_q    <= hi_cnt_d;
      cyc_q       <= cyc_d;
      edge_q      <= edge_d;
      div_q       <= div_d;
      div_valid_q <= div_valid_d;
      err_q       <= err_d;
    end
  end

  assign div       = div_q;
  assign div_valid = div_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Scoreboard bench for uart_autobaud: frames are generated with known edge
// times, the expected divider is computed from the measured span, and a monitor checks results.
module tb_uart_autobaud;

  localparam int DW = 8;
  localparam int GF = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          start;
  logic [DW-1:0] div;
  logic          div_valid;
  logic          busy;
  logic          err;

  typedef struct {
    bit is_err;
    int div;
    bit chk_lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_fall5_cyc = 0;
  int   last_good_div = 0;

  uart_autobaud #(.DIV_WIDTH(DW), .GLITCH_FILTER(GF)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .start    (start),
    .div      (div),
    .div_valid(div_valid),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected outcome for a measured span of n cycles between 1st and 5th falls.
  function automatic exp_t model(input int n);
    exp_t e;
    int   period;
    period    = (n + 4) / 8;
    e.chk_lat = 1'b1;
    if (period < 3 || period - 2 > (1 << DW) - 1) begin
      e.is_err = 1'b1;
      e.div    = 0;
    end else begin
      e.is_err = 1'b0;
      e.div    = period - 2;
    end
    return e;
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int period, input bit jit, input bit push);
    int         t[10];
    bit         v[10];
    logic [7:0] ch;
    logic       lvl;
    int         j;
    ch = 8'h55;
    for (int i = 0; i < 10; i++) begin
      v[i] = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : ch[i-1];
      t[i] = i * period;
      if (jit && i > 0) begin
        j    = int'($urandom_range(0, 2));
        t[i] = t[i] + j - 1;
      end
    end
    if (push) sb.push_back(model(t[8] - t[0]));
    for (int c = 0; c < 10 * period + 2; c++) begin
      lvl = 1'b1;
      for (int i = 0; i < 10; i++) if (c >= t[i]) lvl = v[i];
      rx = lvl;
      if (c == t[8]) last_fall5_cyc = cyc;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input bit chk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (chk) begin
      @(negedge clk);
      check("dv_cleared_by_start", div_valid == 1'b0, div_valid, 0);
      check("busy_after_start", busy == 1'b1, busy, 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("result_timeout", sb.size() == 0, sb.size(), 0);
    sb.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("busy_low_after", busy == 1'b0, busy, 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every err pulse or div_valid rise.
  initial begin
    bit   prev_dv;
    bit   prev_err;
    exp_t e;
    int   lat;
    prev_dv  = 1'b0;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_dv       = 1'b0;
        prev_err      = 1'b0;
        last_good_div = 0;
      end else begin
        if (err) check("err_single_cycle", !prev_err, prev_err, 0);
        if ((err && !prev_err) || (div_valid && !prev_dv)) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 1'b0, int'(err), 0);
          end else begin
            e = sb.pop_front();
            if (err) begin
              check("err_expected", e.is_err, 1, int'(e.is_err));
              check("dv_low_on_err", div_valid == 1'b0, div_valid, 0);
              check("div_held_on_err", int'(div) == last_good_div, div, last_good_div);
            end else begin
              check("success_expected", !e.is_err, 0, int'(e.is_err));
              check("div_value", int'(div) == e.div, div, e.div);
              if (!e.is_err) last_good_div = e.div;
            end
            if (e.chk_lat) begin
              lat = cyc - last_fall5_cyc;
              check("result_latency", lat >= 3 && lat <= 8, lat, 5);
            end
          end
        end
        prev_dv  = div_valid;
        prev_err = err;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bp[4];
    int   per;
    bit   seen;
    exp_t eo;
    bp = '{257, 258, 2, 3};
    rst   = 1'b1;
    rx    = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_div", div == '0, div, 0);
    check("rst_div_valid", div_valid == 1'b0, div_valid, 0);
    check("rst_busy", busy == 1'b0, busy, 0);
    check("rst_err", err == 1'b0, err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);

    pulse_start(1'b1); idle(20); send_frame(16, 1'b0, 1'b1); wait_done(200);
    pulse_start(1'b1); idle(20); send_frame(10, 1'b0, 1'b1); wait_done(200);
    repeat (3) begin
      pulse_start(1'b1); idle(20); send_frame(11, 1'b1, 1'b1); wait_done(200);
    end

    foreach (bp[k]) begin
      pulse_start(1'b1); idle(20); send_frame(bp[k], 1'b0, 1'b1); wait_done(200);
    end

    repeat (8) begin
      per = int'($urandom_range(3, 300));
      pulse_start(1'b1); idle(20);
      send_frame(per, (per >= 8) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1);
      wait_done(200);
    end

    // Line stuck low after the first fall.
    pulse_start(1'b1); idle(20);
    eo.is_err = 1'b1; eo.div = 0; eo.chk_lat = 1'b0;
    sb.push_back(eo);
    rx = 1'b0;
    repeat (4200) begin
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
    wait_done(50);

    // start during MEASURE is ignored.
    pulse_start(1'b1); idle(20);
    fork
      send_frame(16, 1'b0, 1'b1);
      begin
        repeat (60) @(posedge clk);
        #1;
        pulse_start(1'b0);
      end
    join
    wait_done(200);

    // start while a frame is in flight: must wait for 16 high cycles.
    fork
      send_frame(10, 1'b0, 1'b0);
      begin
        repeat (25) @(posedge clk);
        #1;
        pulse_start(1'b0);
      end
    join
    @(negedge clk);
    check("waiting_for_idle_line", busy == 1'b1, busy, 1);
    check("no_result_from_partial", sb.size() == 0 && div_valid == 1'b0, div_valid, 0);
    @(posedge clk);
    #1;
    idle(20); send_frame(12, 1'b0, 1'b1); wait_done(200);

    // Reset mid-measurement.
    pulse_start(1'b1); idle(20);
    rx = 1'b0; repeat (16) begin @(posedge clk); #1; end
    rx = 1'b1; repeat (16) begin @(posedge clk); #1; end
    rx = 1'b0; repeat (8) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_div", div == '0, div, 0);
    check("midrst_div_valid", div_valid == 1'b0, div_valid, 0);
    check("midrst_busy", busy == 1'b0, busy, 0);
    check("midrst_err", err == 1'b0, err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx  = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (err || busy) seen = 1'b1;
    end
    check("quiet_after_rst", !seen, seen, 0);
    @(posedge clk);
    #1;
    pulse_start(1'b1); idle(20); send_frame(16, 1'b0, 1'b1); wait_done(200);

    check("scoreboard_empty", sb.size() == 0, sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
